soc_ram_arb: RTL and testbench
==============================

SOC_RAM_ARB -- requirements
Module: soc_ram_arb

Interface
REQ-001 Parameter: TIMEOUT_CYC, 255, max cycles a granted access may wait for downstream rdy (range 2..65535).
REQ-002 Parameter: FIXED_PRIO, 0, 1 = s0 always wins ties; 0 = round-robin.
REQ-003 Port: clk  input  1  single clock for all logic; the clk/arst_n members of attached soc_if instances are not used.
REQ-004 Port: srst  input  1  reset, synchronous and active-high.
REQ-005 Port: s0  soc_if.SLV  bundle  requester 0 (CPU data port).
REQ-006 Port: s1  soc_if.SLV  bundle  requester 1 (DMA port).
REQ-007 Port: m  soc_if.MST  bundle  downstream to one soc_ram instance.
REQ-008 Port: err_clr  input  1  clears err.
REQ-009 Port: err  output  1  sticky: a granted access timed out.

Function
REQ-010 States: IDLE, GNT0, GNT1 (arb_state_t); one access in flight at a time.
REQ-011 IDLE: if exactly one sN.vld=1, go to GNTN next edge; if both, winner per REQ-012; if none, stay.
REQ-012 Round-robin: tie goes to the requester not granted last; last-grant pointer resets to s1, so first tie grants s0; FIXED_PRIO=1 always grants s0.
REQ-013 In GNTN: m.vld=1, m.addr/m.we/m.wdat = sN fields combinationally; in IDLE, m.vld=0 and m.addr/m.we/m.wdat = 0 (m.we must be 0 because downstream asserts rdy on |we regardless of vld).
REQ-014 In GNTN: sN.rdy = m.rdy and sN.rdat = m.rdat; the other requester gets rdy=0 and rdat=0.
REQ-015 GNTN with m.rdy=1 -> IDLE next edge; one IDLE bubble between consecutive grants.
REQ-016 Latency from sN.vld rise (IDLE, no contention): write rdy at +1 cycle; read rdy at +2 cycles.
REQ-017 m.rdy observed in IDLE is ignored (never forwarded).
REQ-018 Requesters hold vld/addr/we/wdat stable until rdy; a vld drop in GNTN without rdy is a protocol violation and the arbiter stays in GNTN.
REQ-019 Watchdog: counter of width $clog2(TIMEOUT_CYC+1) clears on grant and increments each GNTN cycle with m.rdy=0.
REQ-020 When the counter equals TIMEOUT_CYC with m.rdy=0: sN.rdy=1 and sN.rdat=ARB_ERR_RDAT (32'hDEAD_BEEF) that cycle, err set, IDLE next edge.
REQ-021 Timeout and m.rdy in the same cycle: m.rdy wins, normal completion, err unchanged.
REQ-022 err_clr and a new timeout in the same cycle: err ends at 1 (set wins).
REQ-023 Losing requester keeps vld; it is granted on the next IDLE evaluation (no starvation in round-robin mode).

Reset
REQ-024 srst=1 at an edge: state=IDLE, counter=0, last-grant pointer=s1, err=0; all outputs read as REQ-013/REQ-014 IDLE values from the next cycle.
REQ-025 srst during GNTN: the access is abandoned with no rdy to the requester; a late downstream rdy arriving in IDLE is ignored per REQ-017.

Structure
REQ-026 arb_state_t and ARB_ERR_RDAT are placed in soc_pkg; soc_data_t, soc_we_t and SOC_ADDRL are taken from soc_pkg.
REQ-027 Single module with no sub-modules; target 150-250 lines of RTL.

Verification
REQ-028 s0 writes 32'h1234_5678, we=4'hF, to addr 0x10 -> s0.rdy at +1; an s0 read of 0x10 then returns 32'h1234_5678 with rdy at +2; s1.rdy stays 0 throughout.
REQ-029 s0 and s1 raise vld in the same cycle, repeated 4 times with FIXED_PRIO=0 -> grants in order s0,s1,s0,s1; with FIXED_PRIO=1 -> s0 served first every time.
REQ-030 Downstream stub never asserts rdy, TIMEOUT_CYC=8 -> rdy at grant+8 with rdat=32'hDEAD_BEEF and err=1; err_clr pulse -> err=0.
REQ-031 srst asserted one cycle into a read grant -> no sN.rdy; m.vld=0 and m.we=0 next cycle; the stale downstream rdy that follows is not forwarded.
REQ-032 Random mixed traffic from both ports (2000 accesses) against a reference memory model -> all read data match; no cycle with m.we!=0 in IDLE.

Source files
------------

// File: rtl/soc_pkg.sv
// Shared types and constants for the SoC RAM path: bus widths, arbiter
// state encoding and the data word returned on an arbiter timeout.
package soc_pkg;

  localparam int unsigned SOC_ADDRL = 12;

  typedef logic [31:0] soc_data_t;
  typedef logic [3:0]  soc_we_t;

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1
  } arb_state_t;

  localparam soc_data_t ARB_ERR_RDAT = 32'hDEAD_BEEF;

endpackage

// File: rtl/soc_if.sv
// Valid/ready memory bus: the master holds vld/addr/we/wdat until rdy,
// and rdat is valid in the rdy cycle of a read.
interface soc_if
  import soc_pkg::*;
(
  input logic clk,
  input logic arst_n
);

  logic                 vld;
  logic                 rdy;
  logic [SOC_ADDRL-1:0] addr;
  soc_we_t              we;
  soc_data_t            wdat;
  soc_data_t            rdat;

  modport MST (output vld, addr, we, wdat, input rdy, rdat);
  modport SLV (input vld, addr, we, wdat, output rdy, rdat);

  a_ctrl_known: assert property (@(posedge clk) disable iff (!arst_n)
    !$isunknown({vld, rdy, we}));

endinterface

// File: rtl/soc_ram_arb.sv
// Two-requester arbiter in front of a single soc_ram: one access in flight,
// round-robin or fixed priority, with a watchdog on the downstream rdy.
module soc_ram_arb
  import soc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter bit          FIXED_PRIO  = 1'b0
) (
  input  logic clk,
  input  logic srst,
  soc_if.SLV   s0,
  soc_if.SLV   s1,
  soc_if.MST   m,
  input  logic err_clr,
  output logic err
);

  localparam int unsigned     CW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]   TO_MAX = CW'(TIMEOUT_CYC);

  arb_state_t    state;
  logic          last_s1;
  logic [CW-1:0] wd_cnt;

  logic sel0;
  logic sel1;
  logic busy;
  logic tmo;
  logic done;

  // m.rdy outranks the watchdog when both land in the same cycle
  always_comb begin
    sel0 = (state == GNT0);
    sel1 = (state == GNT1);
    busy = sel0 | sel1;
    tmo  = busy && !m.rdy && (wd_cnt == TO_MAX);
    done = busy && (m.rdy || tmo);
  end

  // Idle keeps we at zero: the RAM acknowledges any nonzero we even without vld
  always_comb begin
    m.vld  = busy;
    m.addr = '0;
    m.we   = '0;
    m.wdat = '0;
    if (sel0) begin
      m.addr = s0.addr;
      m.we   = s0.we;
      m.wdat = s0.wdat;
    end else if (sel1) begin
      m.addr = s1.addr;
      m.we   = s1.we;
      m.wdat = s1.wdat;
    end
  end

  always_comb begin
    s0.rdy  = sel0 && (m.rdy || tmo);
    s1.rdy  = sel1 && (m.rdy || tmo);
    s0.rdat = '0;
    s1.rdat = '0;
    if (sel0) s0.rdat = tmo ? ARB_ERR_RDAT : m.rdat;
    if (sel1) s1.rdat = tmo ? ARB_ERR_RDAT : m.rdat;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state   <= IDLE;
      last_s1 <= 1'b1;
      wd_cnt  <= '0;
      err     <= 1'b0;
    end else begin
      if (tmo) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end

      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (s0.vld && (!s1.vld || FIXED_PRIO || last_s1)) begin
            state   <= GNT0;
            last_s1 <= 1'b0;
          end else if (s1.vld) begin
            state   <= GNT1;
            last_s1 <= 1'b1;
          end
        end
        GNT0, GNT1: begin
          if (done) begin
            state <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_ram_arb.sv
// Directed and random checks of soc_ram_arb: one round-robin and one
// fixed-priority instance, each in front of a behavioural RAM.
module tb_soc_ram_arb;
  import soc_pkg::*;

  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic srst;
  logic err_clr;
  logic err_w [2];
  logic mute  [2];
  logic ref_on = 1'b0;

  logic                 vld_r  [2][2];
  logic [SOC_ADDRL-1:0] addr_r [2][2];
  soc_we_t              we_r   [2][2];
  soc_data_t            wdat_r [2][2];
  logic                 rdy_w  [2][2];
  soc_data_t            rdat_w [2][2];
  logic                 m_vld_w [2];
  soc_we_t              m_we_w  [2];
  logic                 m_rdy_w [2];

  int        cyc = 0;
  int        fin [2][2];
  int        n_chk = 0;
  int        n_fail = 0;
  soc_data_t ref_mem [4096];
  soc_data_t rd;
  int        lat;
  soc_data_t rd_t  [4];
  int        lat_t [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : gen_d
    soc_if s0_if (.clk(clk), .arst_n(1'b1));
    soc_if s1_if (.clk(clk), .arst_n(1'b1));
    soc_if m_if  (.clk(clk), .arst_n(1'b1));

    soc_ram_arb #(.TIMEOUT_CYC(TO), .FIXED_PRIO(1'(g))) dut (
      .clk(clk), .srst(srst), .s0(s0_if), .s1(s1_if), .m(m_if),
      .err_clr(err_clr), .err(err_w[g])
    );

    assign s0_if.vld  = vld_r[g][0];
    assign s0_if.addr = addr_r[g][0];
    assign s0_if.we   = we_r[g][0];
    assign s0_if.wdat = wdat_r[g][0];
    assign s1_if.vld  = vld_r[g][1];
    assign s1_if.addr = addr_r[g][1];
    assign s1_if.we   = we_r[g][1];
    assign s1_if.wdat = wdat_r[g][1];
    assign rdy_w[g][0]  = s0_if.rdy;
    assign rdy_w[g][1]  = s1_if.rdy;
    assign rdat_w[g][0] = s0_if.rdat;
    assign rdat_w[g][1] = s1_if.rdat;
    assign m_vld_w[g] = m_if.vld;
    assign m_we_w[g]  = m_if.we;
    assign m_rdy_w[g] = m_if.rdy;

    // RAM: write acked same cycle on |we, read acked one cycle later
    soc_data_t mem [4096];
    logic      rd_pend = 1'b0;
    soc_data_t rd_dat  = '0;
    int        we_viol = 0;
    int        spurious = 0;

    initial for (int i = 0; i < 4096; i++) mem[i] = '0;

    assign m_if.rdy  = !mute[g] && ((m_if.we != '0) || rd_pend);
    assign m_if.rdat = rd_dat;

    always @(posedge clk) begin
      rd_pend <= m_if.vld && (m_if.we == '0) && !rd_pend && !mute[g];
      rd_dat  <= mem[m_if.addr];
      for (int b = 0; b < 4; b++)
        if (m_if.we[b] && !mute[g]) mem[m_if.addr][8*b +: 8] <= m_if.wdat[8*b +: 8];
    end

    always @(negedge clk) begin
      if (!m_if.vld && (m_if.we != '0)) we_viol++;
      if ((s0_if.rdy && !s0_if.vld) || (s1_if.rdy && !s1_if.vld) || (s0_if.rdy && s1_if.rdy))
        spurious++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered and left at posedge+1; lat counts clock edges from vld rise to rdy
  task automatic access(input int d, input int p, input logic [SOC_ADDRL-1:0] a,
                        input soc_we_t w, input soc_data_t wd,
                        output soc_data_t rdo, output int lato);
    vld_r[d][p] = 1'b1; addr_r[d][p] = a; we_r[d][p] = w; wdat_r[d][p] = wd;
    lato = -1;
    rdo  = '0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rdy_w[d][p]) begin
        lato = n;
        rdo  = rdat_w[d][p];
        fin[d][p] = cyc;
        break;
      end
    end
    if (lato < 0) check("wait_rdy", 32'd0, 32'd1);
    step();
    vld_r[d][p] = 1'b0; addr_r[d][p] = '0; we_r[d][p] = '0; wdat_r[d][p] = '0;
  endtask

  always @(negedge clk) begin
    if (ref_on) begin
      for (int p = 0; p < 2; p++) begin
        if (rdy_w[0][p] && vld_r[0][p]) begin
          if (we_r[0][p] != '0) begin
            for (int b = 0; b < 4; b++)
              if (we_r[0][p][b]) ref_mem[addr_r[0][p]][8*b +: 8] = wdat_r[0][p][8*b +: 8];
          end else begin
            check("rand_rd", rdat_w[0][p], ref_mem[addr_r[0][p]]);
          end
        end
      end
    end
  end

  task automatic rand_port(input int p);
    logic [SOC_ADDRL-1:0] a;
    soc_we_t   w;
    soc_data_t r;
    int        l;
    for (int i = 0; i < 1000; i++) begin
      a = SOC_ADDRL'(32'h100 + $urandom_range(0, 31));
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      access(0, p, a, w, $urandom, r, l);
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    srst = 1'b1;
    err_clr = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mute[d] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        vld_r[d][p] = 1'b0; addr_r[d][p] = '0; we_r[d][p] = '0; wdat_r[d][p] = '0;
        fin[d][p] = 0;
      end
    end
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    step();
    step();
    srst = 1'b0;
    @(negedge clk);
    check("rst_m_vld", 32'(m_vld_w[0]), 32'd0);
    check("rst_m_we", 32'(m_we_w[0]), 32'd0);
    check("rst_err", 32'(err_w[0]), 32'd0);
    check("rst_s0_rdy", 32'(rdy_w[0][0]), 32'd0);
    step();

    // Basic write/read latency, byte enables, s1 path
    access(0, 0, 12'h010, 4'hF, 32'h1234_5678, rd, lat);
    check("wr_lat", lat, 1);
    access(0, 0, 12'h010, 4'h0, '0, rd, lat);
    check("rd_lat", lat, 2);
    check("rd_dat", rd, 32'h1234_5678);
    check("s1_quiet", gen_d[0].spurious, 0);
    access(0, 0, 12'h010, 4'b0011, 32'hAAAA_BBBB, rd, lat);
    access(0, 1, 12'h010, 4'h0, '0, rd, lat);
    check("s1_rd_lat", lat, 2);
    check("s1_rd_dat", rd, 32'h1234_BBBB);

    // Simultaneous requests on both instances
    for (int r = 0; r < 4; r++) begin
      fork
        access(0, 0, SOC_ADDRL'(32'h20 + r), 4'hF, 32'(r), rd_t[0], lat_t[0]);
        access(0, 1, SOC_ADDRL'(32'h30 + r), 4'hF, 32'(r), rd_t[1], lat_t[1]);
        access(1, 0, SOC_ADDRL'(32'h20 + r), 4'hF, 32'(r), rd_t[2], lat_t[2]);
        access(1, 1, SOC_ADDRL'(32'h30 + r), 4'hF, 32'(r), rd_t[3], lat_t[3]);
      join
      check("rr_tie_s0_first", 32'(fin[0][0] < fin[0][1]), 32'd1);
      check("fp_tie_s0_first", 32'(fin[1][0] < fin[1][1]), 32'd1);
    end
    fork
      access(0, 0, 12'h050, 4'hF, 32'h1, rd_t[0], lat_t[0]);
      access(1, 0, 12'h050, 4'hF, 32'h1, rd_t[2], lat_t[2]);
    join
    fork
      access(0, 0, 12'h051, 4'hF, 32'h2, rd_t[0], lat_t[0]);
      access(0, 1, 12'h052, 4'hF, 32'h3, rd_t[1], lat_t[1]);
      access(1, 0, 12'h051, 4'hF, 32'h2, rd_t[2], lat_t[2]);
      access(1, 1, 12'h052, 4'hF, 32'h3, rd_t[3], lat_t[3]);
    join
    check("rr_after_s0_s1_first", 32'(fin[0][1] < fin[0][0]), 32'd1);
    check("fp_after_s0_s0_first", 32'(fin[1][0] < fin[1][1]), 32'd1);

    // Watchdog: downstream silent
    mute[0] = 1'b1;
    access(0, 0, 12'h040, 4'hF, 32'h55, rd, lat);
    check("tmo_lat", lat, TO + 1);
    check("tmo_rdat", rd, 32'hDEAD_BEEF);
    @(negedge clk);
    check("tmo_err_set", 32'(err_w[0]), 32'd1);
    mute[0] = 1'b0;
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clk);
    check("err_cleared", 32'(err_w[0]), 32'd0);
    step();

    // Clear coinciding with a fresh timeout: set wins
    mute[0] = 1'b1;
    err_clr = 1'b1;
    access(0, 1, 12'h041, 4'hF, 32'h66, rd, lat);
    @(negedge clk);
    check("clr_vs_set_err", 32'(err_w[0]), 32'd1);
    err_clr = 1'b0;
    mute[0] = 1'b0;
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;

    // Downstream rdy arrives exactly on the timeout cycle
    mute[0] = 1'b1;
    fork
      access(0, 0, 12'h044, 4'hF, 32'hCAFE_F00D, rd, lat);
      begin
        repeat (TO + 1) @(posedge clk);
        #2 mute[0] = 1'b0;
      end
    join
    check("late_rdy_lat", lat, TO + 1);
    @(negedge clk);
    check("late_rdy_err", 32'(err_w[0]), 32'd0);
    step();
    access(0, 0, 12'h044, 4'h0, '0, rd, lat);
    check("late_rdy_data", rd, 32'hCAFE_F00D);

    // Reset abandons a read grant; err set first so the reset of err is visible
    mute[0] = 1'b1;
    access(0, 0, 12'h045, 4'hF, 32'h77, rd, lat);
    mute[0] = 1'b0;
    vld_r[0][0] = 1'b1; addr_r[0][0] = 12'h010; we_r[0][0] = 4'h0;
    step();
    srst = 1'b1;
    @(negedge clk);
    check("srst_gnt_no_rdy", 32'(rdy_w[0][0]), 32'd0);
    step();
    srst = 1'b0;
    vld_r[0][0] = 1'b0; addr_r[0][0] = '0;
    @(negedge clk);
    check("srst_stale_rdy_blocked", 32'(rdy_w[0][0]), 32'd0);
    check("srst_m_vld", 32'(m_vld_w[0]), 32'd0);
    check("srst_m_we", 32'(m_we_w[0]), 32'd0);
    check("srst_err", 32'(err_w[0]), 32'd0);
    step();

    // Random traffic against the reference memory
    ref_on = 1'b1;
    fork
      rand_port(0);
      rand_port(1);
    join
    ref_on = 1'b0;

    check("we_in_idle_rr", gen_d[0].we_viol, 0);
    check("we_in_idle_fp", gen_d[1].we_viol, 0);
    check("spurious_rdy_rr", gen_d[0].spurious, 0);
    check("spurious_rdy_fp", gen_d[1].spurious, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
